mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported 128-word `Memory` block. It accepts word read/write requests from an instruction-fetch port (port 0) and a data port (port 1), grants one at a time, and drives the memory's CS/WE/ADDR and the shared tri-state `Mem_Bus`. It returns read data and a one-cycle acknowledge to the granted requester. It sits between the CPU front-end/LSU and `Memory`. It operates on the posedge of `ClK`, while `Memory` acts on the negedge.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for mem_arbiter: FSM states, requester port IDs, memory geometry.
package mem_arb_pkg;

  localparam int MEM_WORDS = 128;
  localparam int MEM_AW    = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_IF   = 1'b0,
    PORT_DATA = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack bundle for both requesters plus the Memory control outputs of mem_arbiter.
// slave = arbiter side, master = requester side.
interface mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ack;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ack;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              busy;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_rdata, p0_ack, p1_rdata, p1_ack,
    output mem_cs, mem_we, mem_addr, busy
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_rdata, p0_ack, p1_rdata, p1_ack,
    input  busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select for mem_arbiter. Ties go to the port that did not win last
// when MEM_ARB_ROUND_ROBIN_EN is defined, otherwise port 0 always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_e      last_gnt,
  output logic       gnt_vld,
  output port_e      gnt_id
);

  port_e tie_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign tie_id = (last_gnt == PORT_IF) ? PORT_DATA : PORT_IF;
`else
  port_e unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign tie_id          = PORT_IF;
`endif

  always_comb begin
    gnt_vld = |req;
    gnt_id  = PORT_IF;
    case (req)
      2'b10:   gnt_id = PORT_DATA;
      2'b11:   gnt_id = tie_id;
      default: gnt_id = PORT_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported Memory: IDLE -> ACCESS -> DONE, ack one cycle
// after ACCESS, one access per 3 cycles. Tie policy selected by MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 128
) (
  input  logic              ClK,
  input  logic              Reset,
  mem_arbiter_if.slave      bus_if,
  inout  wire  [DATA_W-1:0] mem_bus
);

  import mem_arb_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  state_e            state_q, state_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  port_e             gnt_q, gnt_d;
  port_e             last_gnt_q, last_gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              gnt_vld;
  port_e             gnt_id;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  mem_arb_pick u_pick (
    .req      ({bus_if.p1_req, bus_if.p0_req}),
    .last_gnt (last_gnt_q),
    .gnt_vld  (gnt_vld),
    .gnt_id   (gnt_id)
  );

  assign win_we    = (gnt_id == PORT_DATA) ? bus_if.p1_we    : bus_if.p0_we;
  assign win_addr  = (gnt_id == PORT_DATA) ? bus_if.p1_addr  : bus_if.p0_addr;
  assign win_wdata = (gnt_id == PORT_DATA) ? bus_if.p1_wdata : bus_if.p0_wdata;

  always_comb begin
    state_d    = state_q;
    mem_cs_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    ack_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d    = ACCESS;
          mem_cs_d   = 1'b1;
          mem_we_d   = win_we;
          // Out-of-range addresses wrap onto the physical array.
          mem_addr_d = ADDR_W'(win_addr[AW-1:0]);
          wdata_d    = win_wdata;
          gnt_d      = gnt_id;
          last_gnt_d = gnt_id;
        end
      end
      ACCESS: begin
        state_d = DONE;
        ack_d   = (gnt_q == PORT_DATA) ? 2'b10 : 2'b01;
        if (!mem_we_q) begin
          if (gnt_q == PORT_DATA) rdata1_d = mem_bus;
          else                    rdata0_d = mem_bus;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ClK) begin
    if (Reset) begin
      state_q    <= IDLE;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      gnt_q      <= PORT_IF;
      last_gnt_q <= PORT_DATA;
      ack_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_cs_q   <= mem_cs_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      ack_q      <= ack_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // cs/we are registered, so Memory only drives on reads and never overlaps this driver.
  assign mem_bus = (mem_cs_q && mem_we_q) ? wdata_q : {DATA_W{1'bz}};

  assign bus_if.mem_cs   = mem_cs_q;
  assign bus_if.mem_we   = mem_we_q;
  assign bus_if.mem_addr = mem_addr_q;
  assign bus_if.p0_ack   = ack_q[0];
  assign bus_if.p1_ack   = ack_q[1];
  assign bus_if.p0_rdata = rdata0_q;
  assign bus_if.p1_rdata = rdata1_q;
  assign bus_if.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: negedge Memory stub on the shared bus, directed cases, then random
// single/tied requests against a queue-based grant-order and shadow-memory model.
module tb_mem_arbiter;

  logic       ClK = 1'b0;
  logic       Reset = 1'b1;
  wire [31:0] mem_bus;

  mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) ifc ();

  mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(128)) dut (
    .ClK     (ClK),
    .Reset   (Reset),
    .bus_if  (ifc.slave),
    .mem_bus (mem_bus)
  );

  always #5 ClK = ~ClK;

  // Memory stub: acts on the negedge, drives the bus on reads until the next negedge.
  logic [31:0] mem_array [128];
  logic        mem_oe  = 1'b0;
  logic [31:0] mem_drv = 32'h0;
  assign mem_bus = mem_oe ? mem_drv : 32'hzzzz_zzzz;

  always @(negedge ClK) begin
    if (ifc.mem_cs && !ifc.mem_we) begin
      mem_drv = mem_array[ifc.mem_addr[6:0]];
      mem_oe  = 1'b1;
    end else begin
      mem_oe = 1'b0;
    end
    if (ifc.mem_cs && ifc.mem_we) mem_array[ifc.mem_addr[6:0]] = mem_bus;
  end

  int conflicts = 0;
  int ack_seen  = 0;
  always @(negedge ClK) begin
    #2;
    if (ifc.mem_cs && ifc.mem_we && mem_oe) conflicts++;
    if (ifc.p0_ack) ack_seen++;
    if (ifc.p1_ack) ack_seen++;
  end

  // Reference model
  logic [31:0] ref_mem [128];
  logic [31:0] exp_rd [2];
  int          model_last;
  int          acks_expected = 0;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ClK);
    #1;
  endtask

  task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1);
    int          order[$];
    int          cyc;
    int          idx;
    int          p;
    logic        we;
    logic [6:0]  ai;
    logic [31:0] d;
    if (r0 && r1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      p = (model_last == 0) ? 1 : 0;
`else
      p = 0;
`endif
      order.push_back(p);
      order.push_back(1 - p);
    end else if (r0) begin
      order.push_back(0);
    end else if (r1) begin
      order.push_back(1);
    end
    acks_expected += order.size();
    ifc.p0_req = r0; ifc.p0_we = w0; ifc.p0_addr = a0; ifc.p0_wdata = d0;
    ifc.p1_req = r1; ifc.p1_we = w1; ifc.p1_addr = a1; ifc.p1_wdata = d1;
    cyc = 0;
    idx = 0;
    while (order.size() > 0 && cyc < 12) begin
      tick();
      cyc++;
      p  = order[0];
      we = (p == 1) ? w1 : w0;
      ai = (p == 1) ? a1[6:0] : a0[6:0];
      d  = (p == 1) ? d1 : d0;
      if (ifc.mem_cs) begin
        check("mem_addr", ifc.mem_addr, 32'(ai));
        check("mem_we", 32'(ifc.mem_we), 32'(we));
        if (we) check("mem_bus_wdata", mem_bus, d);
      end
      if (ifc.p0_ack || ifc.p1_ack) begin
        check("ack_port", 32'({ifc.p1_ack, ifc.p0_ack}), (p == 1) ? 32'd2 : 32'd1);
        check("ack_latency", 32'(cyc), 32'(2 + 3 * idx));
        if (we) ref_mem[ai] = d;
        else    exp_rd[p] = ref_mem[ai];
        check("p0_rdata", ifc.p0_rdata, exp_rd[0]);
        check("p1_rdata", ifc.p1_rdata, exp_rd[1]);
        model_last = p;
        if (p == 0) ifc.p0_req = 1'b0;
        else        ifc.p1_req = 1'b0;
        void'(order.pop_front());
        idx++;
      end
    end
    check("round_complete", 32'(order.size()), 32'd0);
    ifc.p0_req = 1'b0;
    ifc.p1_req = 1'b0;
    tick();
    check("ack_one_cycle", 32'({ifc.p1_ack, ifc.p0_ack}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int pat;
    for (int i = 0; i < 128; i++) begin
      mem_array[i] = 32'h0;
      ref_mem[i]   = 32'h0;
    end
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    model_last = 1;
    ifc.p0_req = 1'b0; ifc.p0_we = 1'b0; ifc.p0_addr = '0; ifc.p0_wdata = '0;
    ifc.p1_req = 1'b0; ifc.p1_we = 1'b0; ifc.p1_addr = '0; ifc.p1_wdata = '0;
    Reset = 1'b1;
    tick();
    tick();
    check("rst_mem_cs", 32'(ifc.mem_cs), 32'd0);
    check("rst_mem_we", 32'(ifc.mem_we), 32'd0);
    check("rst_mem_addr", ifc.mem_addr, 32'd0);
    check("rst_p0_ack", 32'(ifc.p0_ack), 32'd0);
    check("rst_p1_ack", 32'(ifc.p1_ack), 32'd0);
    check("rst_p0_rdata", ifc.p0_rdata, 32'd0);
    check("rst_p1_rdata", ifc.p1_rdata, 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    Reset = 1'b0;
    tick();

    // Ties: reads, then writes, then reads back
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 32'd3, 32'd4, 32'h0, 32'h0);
    run_round(1'b1, 1'b1, 1'b1, 1'b1, 32'd3, 32'd4, 32'h1111_0003, 32'h2222_0004);
    run_round(1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 32'd3, 32'h0, 32'h0);

    // Write then read on port 0
    run_round(1'b1, 1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'h0);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0);

    // Address wrap: 133 lands on word 5
    run_round(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd133, 32'h0, 32'h1234_5678);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'h0, 32'h0);

    // Held request on port 1: not regranted out of DONE
    ifc.p1_req = 1'b1; ifc.p1_we = 1'b0; ifc.p1_addr = 32'd5;
    acks_expected++;
    tick();
    check("held_access_cs", 32'(ifc.mem_cs), 32'd1);
    tick();
    check("held_ack", 32'(ifc.p1_ack), 32'd1);
    exp_rd[1] = ref_mem[5];
    model_last = 1;
    check("held_rdata", ifc.p1_rdata, exp_rd[1]);
    tick();
    check("held_no_regrant_cs", 32'(ifc.mem_cs), 32'd0);
    check("held_no_regrant_busy", 32'(ifc.busy), 32'd0);
    ifc.p1_req = 1'b0;
    tick();
    check("held_idle_cs", 32'(ifc.mem_cs), 32'd0);
    run_round(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd5, 32'h0, 32'h0);

    // Reset at the posedge ending a write ACCESS
    ifc.p0_req = 1'b1; ifc.p0_we = 1'b1; ifc.p0_addr = 32'd9; ifc.p0_wdata = 32'hA5A5_A5A5;
    tick();
    check("rstacc_cs", 32'(ifc.mem_cs), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    ifc.p0_req = 1'b0;
    ref_mem[9] = 32'hA5A5_A5A5;
    exp_rd[0]  = 32'h0;
    exp_rd[1]  = 32'h0;
    model_last = 1;
    check("rstacc_no_ack", 32'({ifc.p1_ack, ifc.p0_ack}), 32'd0);
    check("rstacc_busy", 32'(ifc.busy), 32'd0);
    check("rstacc_cs_off", 32'(ifc.mem_cs), 32'd0);
    tick();
    check("rstacc_still_no_ack", 32'({ifc.p1_ack, ifc.p0_ack}), 32'd0);
    run_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd0, 32'h0, 32'h0);

    // Random mixed traffic
    issued = 0;
    while (issued < 100) begin
      pat = int'($urandom_range(1, 3));
      run_round(pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)),
                $urandom, $urandom);
      issued += (pat[0] ? 1 : 0) + (pat[1] ? 1 : 0);
    end

    check("bus_conflicts", 32'(conflicts), 32'd0);
    check("ack_total", 32'(ack_seen), 32'(acks_expected));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
